// File: rtl/primus_operand_fetch_if.sv
// Handshake bundle between decode, operand fetch and the ALU writeback path.
// The upstream/ALU side drives the master modport; the fetch stage is the slave.
interface primus_operand_fetch_if #(
    parameter int XLEN = 16,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
);
    logic            instr_valid;
    logic            instr_ready;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [AW-1:0]   rd_addr;
    logic            rd_we;
    logic            issue_valid;
    logic            issue_ready;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [AW-1:0]   rd_addr_q;
    logic            rd_we_q;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            busy;

    modport master (
        output instr_valid, rs1_addr, rs2_addr,
        output rd_addr, rd_we, issue_ready,
        output wb_valid, wb_addr, wb_data,
        input  instr_ready, issue_valid,
        input  rs1_data_q, rs2_data_q,
        input  rd_addr_q, rd_we_q, busy
    );

    modport slave (
        input  instr_valid, rs1_addr, rs2_addr,
        input  rd_addr, rd_we, issue_ready,
        input  wb_valid, wb_addr, wb_data,
        output instr_ready, issue_valid,
        output rs1_data_q, rs2_data_q,
        output rd_addr_q, rd_we_q, busy
    );
endinterface

// File: rtl/primus_operand_fetch.sv
// Operand fetch/issue stage: register file, pending-write scoreboard, issue reg.
// PRIMUS_OPFETCH_BYPASS_EN enables same-cycle writeback forwarding and sb clear.
module primus_operand_fetch #(
    parameter int XLEN = 16,
    parameter int NREG = 32
) (
    input logic                clk_i,
    input logic                rst_ni,
    primus_operand_fetch_if.slave bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {EMPTY, FULL} state_e;

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [AW-1:0]   rd;
        logic            we;
    } issue_t;

    state_e          state;
    issue_t          q;
    issue_t          d;
    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_clr;
    logic [NREG-1:0] sb_set;
    logic [NREG-1:0] sb_haz;
    logic [NREG-1:0] sb_nxt;
    logic            wb_hit;
    logic            hazard;
    logic            ready;
    logic            accept;
    logic            busy_q;

    assign wb_hit = bus.wb_valid && (bus.wb_addr != '0);

    always_comb begin
        sb_clr = '0;
        if (wb_hit) sb_clr[bus.wb_addr] = 1'b1;
    end

    always_comb begin
        sb_set = '0;
        if (accept && bus.rd_we && (bus.rd_addr != '0))
            sb_set[bus.rd_addr] = 1'b1;
    end

    // Set after clear so a same-edge issue to the retiring register wins.
    assign sb_nxt = (sb & ~sb_clr) | sb_set;

`ifdef PRIMUS_OPFETCH_BYPASS_EN
    assign sb_haz = sb & ~sb_clr;
`else
    assign sb_haz = sb;
`endif

    assign hazard =
        (sb_haz[bus.rs1_addr] && (bus.rs1_addr != '0)) ||
        (sb_haz[bus.rs2_addr] && (bus.rs2_addr != '0)) ||
        (bus.rd_we && (bus.rd_addr != '0) && sb_haz[bus.rd_addr]);

    assign ready  = rst_ni && ((state == EMPTY) || bus.issue_ready)
                    && !hazard;
    assign accept = bus.instr_valid && ready;

    always_comb begin
        d.rs1 = rf[bus.rs1_addr];
        d.rs2 = rf[bus.rs2_addr];
`ifdef PRIMUS_OPFETCH_BYPASS_EN
        if (wb_hit && (bus.wb_addr == bus.rs1_addr)) d.rs1 = bus.wb_data;
        if (wb_hit && (bus.wb_addr == bus.rs2_addr)) d.rs2 = bus.wb_data;
`endif
        if (bus.rs1_addr == '0) d.rs1 = '0;
        if (bus.rs2_addr == '0) d.rs2 = '0;
        d.rd = bus.rd_addr;
        d.we = bus.rd_we;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= EMPTY;
            q      <= '0;
            sb     <= '0;
            busy_q <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            unique case (state)
                EMPTY:   if (accept) state <= FULL;
                FULL:    if (bus.issue_ready && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (accept) q <= d;
            if (wb_hit) rf[bus.wb_addr] <= bus.wb_data;
            sb     <= sb_nxt;
            busy_q <= |sb_nxt;
        end
    end

    assign bus.instr_ready = ready;
    assign bus.issue_valid = (state == FULL);
    assign bus.rs1_data_q  = q.rs1;
    assign bus.rs2_data_q  = q.rs2;
    assign bus.rd_addr_q   = q.rd;
    assign bus.rd_we_q     = q.we;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_primus_operand_fetch.sv
// Bench for primus_operand_fetch: directed vectors, literal checks and a
// cycle-level register/pending-set model compared on every falling edge.
module tb_primus_operand_fetch;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    primus_operand_fetch_if bus ();

    primus_operand_fetch dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] m_rf [32];
    bit          m_pend [32];
    bit          m_full;
    logic [15:0] m_q1;
    logic [15:0] m_q2;
    logic [4:0]  m_qrd;
    logic        m_qwe;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pend_seen(input logic [4:0] a);
`ifdef PRIMUS_OPFETCH_BYPASS_EN
        if (bus.wb_valid && bus.wb_addr == a) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    function automatic bit m_hazard();
        return (bus.rs1_addr != 0 && pend_seen(bus.rs1_addr)) ||
               (bus.rs2_addr != 0 && pend_seen(bus.rs2_addr)) ||
               (bus.rd_we && bus.rd_addr != 0 && pend_seen(bus.rd_addr));
    endfunction

    function automatic bit m_ready();
        return rst_n && (!m_full || bus.issue_ready) && !m_hazard();
    endfunction

    function automatic logic [15:0] m_read(input logic [4:0] a);
        if (a == 0) return 16'h0;
`ifdef PRIMUS_OPFETCH_BYPASS_EN
        if (bus.wb_valid && bus.wb_addr == a) return bus.wb_data;
`endif
        return m_rf[a];
    endfunction

    function automatic bit m_busy();
        for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full <= 1'b0;
            m_q1   <= '0;
            m_q2   <= '0;
            m_qrd  <= '0;
            m_qwe  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                m_rf[i]   <= '0;
                m_pend[i] <= 1'b0;
            end
        end else begin
            if (bus.wb_valid && bus.wb_addr != 0) begin
                m_rf[bus.wb_addr]   <= bus.wb_data;
                m_pend[bus.wb_addr] <= 1'b0;
            end
            if (bus.instr_valid && m_ready()) begin
                m_full <= 1'b1;
                m_q1   <= m_read(bus.rs1_addr);
                m_q2   <= m_read(bus.rs2_addr);
                m_qrd  <= bus.rd_addr;
                m_qwe  <= bus.rd_we;
                if (bus.rd_we && bus.rd_addr != 0)
                    m_pend[bus.rd_addr] <= 1'b1;
            end else if (bus.issue_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("m_issue_valid", bus.issue_valid, m_full);
        check("m_instr_ready", bus.instr_ready, m_ready());
        check("m_busy", bus.busy, m_busy());
        if (m_full) begin
            check("m_rs1_q", bus.rs1_data_q, m_q1);
            check("m_rs2_q", bus.rs2_data_q, m_q2);
            check("m_rd_q", bus.rd_addr_q, m_qrd);
            check("m_we_q", bus.rd_we_q, m_qwe);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.instr_valid = 1'b0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
        bus.rd_addr     = '0;
        bus.rd_we       = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
    endtask

    task automatic instr(input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic we);
        bus.instr_valid = 1'b1;
        bus.rs1_addr    = r1;
        bus.rs2_addr    = r2;
        bus.rd_addr     = rd;
        bus.rd_we       = we;
    endtask

    task automatic wb(input logic [4:0] a, input logic [15:0] dat);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = dat;
    endtask

    initial begin
        idle();
        bus.issue_ready = 1'b1;
        tick();
        tick();
        check("rst_issue_valid", bus.issue_valid, 0);
        check("rst_instr_ready", bus.instr_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rs1_q", bus.rs1_data_q, 0);
        rst_n = 1'b1;

        // r3 = 0x1234, then issue rs1=3 rd=4
        wb(5'd3, 16'h1234);
        tick();
        idle();
        instr(5'd3, 5'd0, 5'd4, 1'b1);
        tick();
        idle();
        check("iss_valid", bus.issue_valid, 1);
        check("iss_rs1", bus.rs1_data_q, 16'h1234);
        check("iss_rs2", bus.rs2_data_q, 0);
        check("iss_rd", bus.rd_addr_q, 4);
        check("iss_busy", bus.busy, 1);

        // RAW on r7
        instr(5'd0, 5'd0, 5'd7, 1'b1);
        tick();
        instr(5'd7, 5'd0, 5'd8, 1'b1);
        #1;
        check("raw_stall", bus.instr_ready, 0);
        tick();
        wb(5'd7, 16'hBEEF);
`ifdef PRIMUS_OPFETCH_BYPASS_EN
        #1;
        check("raw_byp_ready", bus.instr_ready, 1);
        tick();
        idle();
`else
        #1;
        check("raw_nobyp_ready", bus.instr_ready, 0);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        check("raw_late_ready", bus.instr_ready, 1);
        tick();
        idle();
`endif
        check("raw_valid", bus.issue_valid, 1);
        check("raw_rs1", bus.rs1_data_q, 16'hBEEF);

        // backpressure while FULL
        bus.issue_ready = 1'b0;
        instr(5'd3, 5'd7, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_ready", bus.instr_ready, 0);
            check("bp_valid", bus.issue_valid, 1);
            check("bp_rs1", bus.rs1_data_q, 16'hBEEF);
            check("bp_rd", bus.rd_addr_q, 8);
        end
        bus.issue_ready = 1'b1;
        #1;
        check("bp_release", bus.instr_ready, 1);
        tick();
        idle();
        check("bp_new_rs1", bus.rs1_data_q, 16'h1234);
        check("bp_new_rs2", bus.rs2_data_q, 16'hBEEF);

        // retire r4, r8
        wb(5'd4, 16'h0444);
        tick();
        wb(5'd8, 16'h0888);
        tick();
        idle();
        check("clr_busy", bus.busy, 0);

        // x0 rules
        wb(5'd0, 16'hFFFF);
        tick();
        idle();
        instr(5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        idle();
        check("x0_rs1", bus.rs1_data_q, 0);
        check("x0_busy", bus.busy, 0);

        // same-edge set/clear on r9
        instr(5'd0, 5'd0, 5'd9, 1'b1);
        tick();
        idle();
        check("se_busy0", bus.busy, 1);
        wb(5'd9, 16'h9999);
        instr(5'd9, 5'd0, 5'd9, 1'b1);
`ifdef PRIMUS_OPFETCH_BYPASS_EN
        tick();
        idle();
`else
        tick();
        bus.wb_valid = 1'b0;
        tick();
        idle();
`endif
        check("se_busy1", bus.busy, 1);
        check("se_rs1", bus.rs1_data_q, 16'h9999);
        wb(5'd9, 16'h9999);
        tick();
        idle();

        // back-to-back issue
        for (int i = 0; i < 6; i++) begin
            instr((i % 2 == 0) ? 5'd3 : 5'd7, 5'd9, 5'd0, 1'b0);
            tick();
            check("tp_valid", bus.issue_valid, 1);
        end
        idle();
        tick();

        // reset mid-FULL with r5 pending
        wb(5'd5, 16'h5555);
        tick();
        idle();
        bus.issue_ready = 1'b0;
        instr(5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        idle();
        check("mr_valid", bus.issue_valid, 1);
        check("mr_busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rst_valid", bus.issue_valid, 0);
        check("mr_rst_busy", bus.busy, 0);
        check("mr_rst_ready", bus.instr_ready, 0);
        tick();
        rst_n = 1'b1;
        bus.issue_ready = 1'b1;
        instr(5'd5, 5'd0, 5'd0, 1'b0);
        tick();
        idle();
        check("mr_r5", bus.rs1_data_q, 0);
        check("mr_valid2", bus.issue_valid, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
